// File: rtl/decode_issue.sv
// Decode-to-execute issue stage: decodes the IF/ID instruction, captures operands
// and control into ID/EX, and inserts a one-cycle bubble on load-use hazards.
module decode_issue #(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   if_valid,
   input  logic [31:0]            if_instr,
   input  logic [31:0]            if_pc_plus4,
   input  logic                   flush,
   output logic [4:0]             reg_rs_id,
   output logic [4:0]             reg_rt_id,
   input  logic [31:0]            reg_rs_value,
   input  logic [31:0]            reg_rt_value,
   output logic                   stall_out,
   output logic                   ex_valid,
   output logic [5:0]             ex_opcode,
   output logic [5:0]             ex_funct,
   output logic [4:0]             ex_shamt,
   output logic [4:0]             ex_rs_id,
   output logic [4:0]             ex_rt_id,
   output logic [31:0]            ex_rs_value,
   output logic [31:0]            ex_rt_value,
   output logic [31:0]            ex_imm_sext,
   output logic [31:0]            ex_pc_plus4,
   output logic                   ex_reg_write,
   output logic [4:0]             ex_write_id,
   output logic                   ex_mem_read,
   output logic [STALL_CNT_W-1:0] stall_count
);

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [31:0] imm_sext;

   assign op       = if_instr[31:26];
   assign rs       = if_instr[25:21];
   assign rt       = if_instr[20:16];
   assign rd       = if_instr[15:11];
   assign shamt    = if_instr[10:6];
   assign funct    = if_instr[5:0];
   assign imm_sext = {{16{if_instr[15]}}, if_instr[15:0]};

   assign reg_rs_id = rs;
   assign reg_rt_id = rt;

   logic [4:0] dec_write_id;
   logic       dec_reg_write;
   logic       dec_mem_read;
   logic       uses_rs;
   logic       uses_rt;

   always_comb begin
      dec_write_id  = 5'd0;
      dec_reg_write = 1'b0;
      dec_mem_read  = 1'b0;
      if (op == 6'h00) begin
         dec_write_id  = rd;
         dec_reg_write = (funct != 6'h08);
      end else if (op >= 6'h08 && op <= 6'h0F) begin
         dec_write_id  = rt;
         dec_reg_write = 1'b1;
      end else if (op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25) begin
         dec_write_id  = rt;
         dec_reg_write = 1'b1;
         dec_mem_read  = 1'b1;
      end else if (op == 6'h03) begin
         dec_write_id  = 5'd31;
         dec_reg_write = 1'b1;
      end
      // $0 is hardwired, so a write to it is never a real write
      if (dec_write_id == 5'd0) begin
         dec_reg_write = 1'b0;
      end
   end

   assign uses_rs = !(op == 6'h02 || op == 6'h03 || op == 6'h0F);
   assign uses_rt = (op == 6'h00 || op == 6'h04 || op == 6'h05 ||
                     op == 6'h28 || op == 6'h29 || op == 6'h2B);

   logic valid_reg;
   logic reg_write_reg;
   logic mem_read_reg;
   logic [4:0] write_id_reg;
   logic hazard;

   assign hazard = if_valid && valid_reg && mem_read_reg && (write_id_reg != 5'd0) &&
                   ((uses_rs && write_id_reg == rs) || (uses_rt && write_id_reg == rt));

   // A flushed instruction is discarded, so holding fetch for it is pointless
   assign stall_out = hazard && !flush;

   logic [5:0]  opcode_reg;
   logic [5:0]  funct_reg;
   logic [4:0]  shamt_reg;
   logic [4:0]  rs_id_reg;
   logic [4:0]  rt_id_reg;
   logic [31:0] rs_value_reg;
   logic [31:0] rt_value_reg;
   logic [31:0] imm_reg;
   logic [31:0] pc_plus4_reg;
   logic [STALL_CNT_W-1:0] stall_cnt_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_reg     <= 1'b0;
         reg_write_reg <= 1'b0;
         mem_read_reg  <= 1'b0;
         write_id_reg  <= 5'd0;
         opcode_reg    <= 6'd0;
         funct_reg     <= 6'd0;
         shamt_reg     <= 5'd0;
         rs_id_reg     <= 5'd0;
         rt_id_reg     <= 5'd0;
         rs_value_reg  <= 32'd0;
         rt_value_reg  <= 32'd0;
         imm_reg       <= 32'd0;
         pc_plus4_reg  <= 32'd0;
      end else if (flush || hazard) begin
         valid_reg     <= 1'b0;
         reg_write_reg <= 1'b0;
         mem_read_reg  <= 1'b0;
      end else begin
         valid_reg     <= if_valid;
         reg_write_reg <= dec_reg_write;
         mem_read_reg  <= dec_mem_read;
         write_id_reg  <= dec_write_id;
         opcode_reg    <= op;
         funct_reg     <= funct;
         shamt_reg     <= shamt;
         rs_id_reg     <= rs;
         rt_id_reg     <= rt;
         rs_value_reg  <= reg_rs_value;
         rt_value_reg  <= reg_rt_value;
         imm_reg       <= imm_sext;
         pc_plus4_reg  <= if_pc_plus4;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_reg <= '0;
      end else if (stall_out && stall_cnt_reg != {STALL_CNT_W{1'b1}}) begin
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
   end

   assign ex_valid     = valid_reg;
   assign ex_reg_write = reg_write_reg;
   assign ex_mem_read  = mem_read_reg;
   assign ex_write_id  = write_id_reg;
   assign ex_opcode    = opcode_reg;
   assign ex_funct     = funct_reg;
   assign ex_shamt     = shamt_reg;
   assign ex_rs_id     = rs_id_reg;
   assign ex_rt_id     = rt_id_reg;
   assign ex_rs_value  = rs_value_reg;
   assign ex_rt_value  = rt_value_reg;
   assign ex_imm_sext  = imm_reg;
   assign ex_pc_plus4  = pc_plus4_reg;
   assign stall_count  = stall_cnt_reg;

endmodule

// File: tb/tb_decode_issue.sv
// Randomised and directed bench for decode_issue, checked each cycle against a
// behavioural model of the ID/EX register; a 2-bit-counter copy covers saturation.
module tb_decode_issue;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        if_valid = 1'b0;
   logic [31:0] if_instr = 32'd0;
   logic [31:0] if_pc_plus4 = 32'd0;
   logic        flush = 1'b0;
   logic [31:0] reg_rs_value = 32'd0;
   logic [31:0] reg_rt_value = 32'd0;

   logic [4:0]  reg_rs_id, reg_rt_id;
   logic        stall_out, ex_valid, ex_reg_write, ex_mem_read;
   logic [5:0]  ex_opcode, ex_funct;
   logic [4:0]  ex_shamt, ex_rs_id, ex_rt_id, ex_write_id;
   logic [31:0] ex_rs_value, ex_rt_value, ex_imm_sext, ex_pc_plus4;
   logic [15:0] stall_count;

   logic [4:0]  s_rs_id, s_rt_id;
   logic        s_stall_out, s_valid, s_reg_write, s_mem_read;
   logic [5:0]  s_opcode, s_funct;
   logic [4:0]  s_shamt, s_ex_rs_id, s_ex_rt_id, s_write_id;
   logic [31:0] s_rs_value, s_rt_value, s_imm, s_pc;
   logic [1:0]  s_stall_count;

   always #5 clock = ~clock;

   decode_issue #(.STALL_CNT_W(16)) u_dut (
      .clock(clock), .reset_n(reset_n), .if_valid(if_valid), .if_instr(if_instr),
      .if_pc_plus4(if_pc_plus4), .flush(flush), .reg_rs_id(reg_rs_id), .reg_rt_id(reg_rt_id),
      .reg_rs_value(reg_rs_value), .reg_rt_value(reg_rt_value), .stall_out(stall_out),
      .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_shamt(ex_shamt),
      .ex_rs_id(ex_rs_id), .ex_rt_id(ex_rt_id), .ex_rs_value(ex_rs_value),
      .ex_rt_value(ex_rt_value), .ex_imm_sext(ex_imm_sext), .ex_pc_plus4(ex_pc_plus4),
      .ex_reg_write(ex_reg_write), .ex_write_id(ex_write_id), .ex_mem_read(ex_mem_read),
      .stall_count(stall_count)
   );

   decode_issue #(.STALL_CNT_W(2)) u_sat (
      .clock(clock), .reset_n(reset_n), .if_valid(if_valid), .if_instr(if_instr),
      .if_pc_plus4(if_pc_plus4), .flush(flush), .reg_rs_id(s_rs_id), .reg_rt_id(s_rt_id),
      .reg_rs_value(reg_rs_value), .reg_rt_value(reg_rt_value), .stall_out(s_stall_out),
      .ex_valid(s_valid), .ex_opcode(s_opcode), .ex_funct(s_funct), .ex_shamt(s_shamt),
      .ex_rs_id(s_ex_rs_id), .ex_rt_id(s_ex_rt_id), .ex_rs_value(s_rs_value),
      .ex_rt_value(s_rt_value), .ex_imm_sext(s_imm), .ex_pc_plus4(s_pc),
      .ex_reg_write(s_reg_write), .ex_write_id(s_write_id), .ex_mem_read(s_mem_read),
      .stall_count(s_stall_count)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [4:0] wid;
      logic       rw;
      logic       mr;
      logic       urs;
      logic       urt;
   } dec_t;

   function automatic dec_t dec(input logic [31:0] i);
      dec_t d;
      logic [5:0] op;
      op = i[31:26];
      d = '0;
      if (op == 6'h00) begin
         d.wid = i[15:11];
         d.rw  = (i[5:0] != 6'h08);
      end else if (op inside {[6'h08:6'h0F]}) begin
         d.wid = i[20:16];
         d.rw  = 1'b1;
      end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
         d.wid = i[20:16];
         d.rw  = 1'b1;
         d.mr  = 1'b1;
      end else if (op == 6'h03) begin
         d.wid = 5'd31;
         d.rw  = 1'b1;
      end
      if (d.wid == 5'd0) d.rw = 1'b0;
      d.urs = !(op inside {6'h02, 6'h03, 6'h0F});
      d.urt = op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
      return d;
   endfunction

   logic        m_valid = 0, m_rw = 0, m_mr = 0;
   logic [4:0]  m_wid = 0, m_shamt = 0, m_rs = 0, m_rt = 0;
   logic [5:0]  m_op = 0, m_funct = 0;
   logic [31:0] m_rsv = 0, m_rtv = 0, m_imm = 0, m_pc = 0;
   int          m_cnt16 = 0, m_cnt2 = 0;
   logic        m_stalled = 0;
   logic        last_stall = 0;

   function automatic logic m_hazard();
      dec_t d;
      d = dec(if_instr);
      return if_valid && m_valid && m_mr && (m_wid != 0) &&
             ((d.urs && m_wid == if_instr[25:21]) || (d.urt && m_wid == if_instr[20:16]));
   endfunction

   task automatic model_reset();
      {m_valid, m_rw, m_mr} = 3'b000;
      m_wid = 0; m_shamt = 0; m_rs = 0; m_rt = 0; m_op = 0; m_funct = 0;
      m_rsv = 0; m_rtv = 0; m_imm = 0; m_pc = 0;
      m_cnt16 = 0; m_cnt2 = 0;
   endtask

   task automatic model_step();
      dec_t d;
      logic hz;
      d  = dec(if_instr);
      hz = m_hazard();
      m_stalled = hz && !flush;
      if (m_stalled) begin
         if (m_cnt16 < 65535) m_cnt16++;
         if (m_cnt2 < 3) m_cnt2++;
      end
      if (flush || hz) begin
         {m_valid, m_rw, m_mr} = 3'b000;
      end else begin
         m_valid = if_valid; m_rw = d.rw; m_mr = d.mr; m_wid = d.wid;
         m_op = if_instr[31:26]; m_funct = if_instr[5:0]; m_shamt = if_instr[10:6];
         m_rs = if_instr[25:21]; m_rt = if_instr[20:16];
         m_rsv = reg_rs_value; m_rtv = reg_rt_value;
         m_imm = {{16{if_instr[15]}}, if_instr[15:0]}; m_pc = if_pc_plus4;
      end
   endtask

   // every-cycle comparison against the model, away from the active edge
   always @(negedge clock) begin
      chk("rs_id", 32'(reg_rs_id), 32'(if_instr[25:21]));
      chk("rt_id", 32'(reg_rt_id), 32'(if_instr[20:16]));
      chk("stall_out", 32'(stall_out), 32'(m_hazard() && !flush));
      chk("sat_stall_out", 32'(s_stall_out), 32'(m_hazard() && !flush));
      chk("ex_valid", 32'(ex_valid), 32'(m_valid));
      chk("ex_reg_write", 32'(ex_reg_write), 32'(m_rw));
      chk("ex_mem_read", 32'(ex_mem_read), 32'(m_mr));
      chk("stall_count", 32'(stall_count), 32'(m_cnt16));
      chk("sat_stall_count", 32'(s_stall_count), 32'(m_cnt2));
      if (m_valid) begin
         chk("ex_opcode", 32'(ex_opcode), 32'(m_op));
         chk("ex_funct", 32'(ex_funct), 32'(m_funct));
         chk("ex_shamt", 32'(ex_shamt), 32'(m_shamt));
         chk("ex_rs_id", 32'(ex_rs_id), 32'(m_rs));
         chk("ex_rt_id", 32'(ex_rt_id), 32'(m_rt));
         chk("ex_rs_value", ex_rs_value, m_rsv);
         chk("ex_rt_value", ex_rt_value, m_rtv);
         chk("ex_imm_sext", ex_imm_sext, m_imm);
         chk("ex_pc_plus4", ex_pc_plus4, m_pc);
         chk("ex_write_id", 32'(ex_write_id), 32'(m_wid));
      end
   end

   // ---------------- stimulus ----------------
   logic [31:0] rf [32];
   logic [31:0] pc = 32'h0040_0004;

   // called at posedge+1; returns at the next posedge+1 with the model updated
   task automatic drive(input logic v, input logic [31:0] ins, input logic fl);
      if_valid = v; if_instr = ins; flush = fl; if_pc_plus4 = pc;
      reg_rs_value = rf[ins[25:21]];
      reg_rt_value = rf[ins[20:16]];
      @(negedge clock);
      last_stall = stall_out;
      @(posedge clock);
      #1;
      model_step();
      if (!m_stalled) pc = pc + 32'd4;
      $display("txn v=%0d instr=%08h flush=%0d stall=%0d ex_valid=%0d cnt=%0d",
               v, ins, fl, last_stall, ex_valid, stall_count);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [5:0]  op;
      r = $urandom;
      case ($urandom_range(0, 15))
         0, 1, 2: op = 6'h00;
         3:       op = 6'(8 + $urandom_range(0, 7));
         4, 5:    op = 6'h23;
         6:       op = 6'h20;
         7:       op = 6'h24;
         8:       op = 6'h03;
         9:       op = 6'h02;
         10:      op = 6'h04;
         11:      op = 6'h2B;
         12:      op = 6'h29;
         13:      op = 6'h25;
         14:      op = 6'h21;
         default: op = 6'($urandom);
      endcase
      rand_instr = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 4)), r[10:0]};
      if (op == 6'h00 && r[31:29] == 3'd0) rand_instr[5:0] = 6'h08;
   endfunction

   localparam logic [31:0] LW2   = 32'h8C22_0000;
   localparam logic [31:0] ADD42 = 32'h0043_2020;
   localparam logic [31:0] LW0   = 32'h8C20_0000;
   localparam logic [31:0] ADD40 = 32'h0003_2020;
   localparam logic [31:0] JMP   = 32'h0800_0010;
   localparam logic [31:0] ADDI  = 32'h2065_FFFC;

   logic [31:0] cur;

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf[0] = 32'd0;
      rf[3] = 32'd10;

      #3;
      chk("reset_ex_valid", 32'(ex_valid), 32'd0);
      chk("reset_stall_count", 32'(stall_count), 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;

      // decode of addi $5,$3,-4
      drive(1'b1, ADDI, 1'b0);
      chk("addi_stall", 32'(last_stall), 32'd0);
      chk("addi_write_id", 32'(ex_write_id), 32'd5);
      chk("addi_reg_write", 32'(ex_reg_write), 32'd1);
      chk("addi_imm", ex_imm_sext, 32'hFFFF_FFFC);
      chk("addi_rs_value", ex_rs_value, 32'd10);

      // load-use: one stall cycle, one bubble, then add issues
      drive(1'b1, LW2, 1'b0);
      chk("lu_lw_stall", 32'(last_stall), 32'd0);
      drive(1'b1, ADD42, 1'b0);
      chk("lu_stall", 32'(last_stall), 32'd1);
      chk("lu_bubble", 32'(ex_valid), 32'd0);
      drive(1'b1, ADD42, 1'b0);
      chk("lu_restart_stall", 32'(last_stall), 32'd0);
      chk("lu_issue_valid", 32'(ex_valid), 32'd1);
      chk("lu_issue_rs", 32'(ex_rs_id), 32'd2);
      chk("lu_count", 32'(stall_count), 32'd1);

      // no false hazards
      drive(1'b1, LW0, 1'b0);
      drive(1'b1, ADD40, 1'b0);
      chk("nf_r0_stall", 32'(last_stall), 32'd0);
      drive(1'b1, LW2, 1'b0);
      drive(1'b1, JMP, 1'b0);
      chk("nf_j_stall", 32'(last_stall), 32'd0);

      // flush overrides stall
      drive(1'b1, LW2, 1'b0);
      drive(1'b1, ADD42, 1'b1);
      chk("fl_stall", 32'(last_stall), 32'd0);
      chk("fl_valid", 32'(ex_valid), 32'd0);
      chk("fl_count", 32'(stall_count), 32'd1);

      // asynchronous reset while ID/EX holds a valid instruction
      drive(1'b1, ADDI, 1'b0);
      chk("pre_reset_valid", 32'(ex_valid), 32'd1);
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      chk("async_ex_valid", 32'(ex_valid), 32'd0);
      chk("async_reg_write", 32'(ex_reg_write), 32'd0);
      chk("async_count", 32'(stall_count), 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;

      // saturation: five back-to-back load-use pairs
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, LW2, 1'b0);
         drive(1'b1, ADD42, 1'b0);
         drive(1'b1, ADD42, 1'b0);
      end
      chk("sat_count2", 32'(s_stall_count), 32'd3);
      chk("sat_count16", 32'(stall_count), 32'd5);

      // randomised traffic; a stalled fetch re-presents the same instruction
      cur = rand_instr();
      for (int n = 0; n < 800; n++) begin
         drive(($urandom_range(0, 7) != 0), cur, ($urandom_range(0, 11) == 0));
         if (!m_stalled) cur = rand_instr();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/decode_issue.md
# decode_issue

Decode-to-execute issue stage of the pipelined MIPS core. Takes the fetched instruction, drives the rs/rt read addresses of the decode register file, decodes the control fields, and captures operands and control into the ID/EX pipeline register. Detects load-use hazards against the instruction currently in ID/EX, inserts a one-cycle bubble and stalls fetch. Also honours branch flushes from execute.

## Interface
Parameters:
- STALL_CNT_W, 16, width of the saturating stall counter

Ports:
- clock  in  1  pipeline clock; ID/EX register updates on posedge
- reset_n  in  1  asynchronous active-low reset
- if_valid  in  1  IF/ID register holds a real instruction
- if_instr  in  32  instruction word from IF/ID
- if_pc_plus4  in  32  PC+4 of that instruction
- flush  in  1  branch/jump taken in execute; squash the decode instruction
- reg_rs_id  out  5  register file read address A = if_instr[25:21] (combinational)
- reg_rt_id  out  5  register file read address B = if_instr[20:16] (combinational)
- reg_rs_value  in  32  register file read data A
- reg_rt_value  in  32  register file read data B
- stall_out  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid  out  1  ID/EX holds a real instruction
- ex_opcode, ex_funct  out  6 each  instr[31:26], instr[5:0]
- ex_shamt  out  5  instr[10:6]
- ex_rs_id, ex_rt_id  out  5 each  source ids, for downstream forwarding
- ex_rs_value, ex_rt_value  out  32 each  captured operands
- ex_imm_sext  out  32  sign-extended instr[15:0]
- ex_pc_plus4  out  32  captured PC+4
- ex_reg_write  out  1  instruction writes a register
- ex_write_id  out  5  destination register id
- ex_mem_read  out  1  instruction is a load
- stall_count  out  STALL_CNT_W  number of load-use stall cycles, saturating

## Operation
- Decode, opcode op = instr[31:26]:
  - R-type: op 0x00. Destination is rd. reg_write = 1 unless funct 0x08 (jr).
  - ALU immediate: op 0x08–0x0F. Destination is rt; reg_write = 1.
  - Loads: op 0x20, 0x21, 0x23, 0x24, 0x25. Destination is rt; reg_write = 1; mem_read = 1.
  - jal: op 0x03. Destination is 31; reg_write = 1.
  - All other opcodes: reg_write = 0; write_id = 0.
  - If the decoded write_id is 0, reg_write is forced to 0.
- Source usage:
  - uses_rs = 1 except for op 0x02, 0x03 and 0x0F.
  - uses_rt = 1 for op 0x00, 0x04, 0x05, 0x28, 0x29 and 0x2B.
- Load-use hazard (combinational), all of the following must hold:
  - if_valid, ex_valid, ex_mem_read, and ex_write_id != 0.
  - (uses_rs and ex_write_id == rs) or (uses_rt and ex_write_id == rt).
- Posedge update, in priority order:
  1. flush: ID/EX loads a bubble.
  2. hazard: ID/EX loads a bubble.
  3. Otherwise ID/EX loads the decoded fields, with ex_valid = if_valid.
- Bubble definition: ex_valid = 0, ex_reg_write = 0, ex_mem_read = 0. The other ex_* fields are don't-care and may hold their old values.
- stall_out = hazard and not flush. A flush overrides the stall, because the stalled instruction is squashed anyway.
- stall_count increments on every posedge where stall_out = 1. It saturates at its maximum value.
- A stall always lasts exactly one cycle: the next cycle ID/EX holds a bubble, so the hazard condition clears.

## Timing
- Reset (reset_n low, asynchronous): every ex_* output = 0 (including ex_valid, ex_reg_write, ex_mem_read) and stall_count = 0. Outputs remain there until the first posedge after reset_n rises.
- reg_rs_id, reg_rt_id and stall_out are combinational from if_instr, if_valid, flush and the ID/EX state.
- Latency: an instruction present at posedge N appears on ex_* after posedge N (one cycle).
- Operand capture: reg_rs_value and reg_rt_value are sampled at posedge. The register file writes on negedge, so a writeback in the same cycle is already visible, and no WB bypass is needed here.
- A reset deassert mid-stall returns the block to the idle state; no stall is carried over.

## Test plan
- Reset: assert reset_n = 0 mid-cycle with ex_valid = 1 -> ex_valid, ex_reg_write and stall_count go to 0 immediately, without waiting for a clock edge.
- Decode: addi $5,$3,-4 (0x2065FFFC), regfile returns $3 = 10 -> next cycle ex_write_id = 5, ex_reg_write = 1, ex_imm_sext = 0xFFFFFFFC, ex_rs_value = 10, stall_out never asserted.
- Load-use: lw $2,0($1) followed by add $4,$2,$3 -> stall_out = 1 for exactly one cycle, ID/EX gets one bubble, then add issues with ex_rs_id = 2; stall_count = 1.
- No false hazard: lw $0,0($1) followed by add $4,$0,$3, and lw $2,0($1) followed by j (op 0x02) -> stall_out stays 0.
- Flush vs stall: hazard condition present and flush = 1 in the same cycle -> stall_out = 0, ex_valid = 0 next cycle, stall_count unchanged.
- Saturation: with STALL_CNT_W = 2, run 5 back-to-back load-use pairs -> stall_count reads 3 and holds.
